nn_input_streamer: RTL

NN_INPUT_STREAMER -- requirements
Module: nn_input_streamer

---
 rtl/nn_input_streamer.sv | 119 +++++++++++
 1 files changed

// File: rtl/nn_input_streamer.sv
// Frame buffer that streams one stored input frame into the network over a
// valid/ready link, then waits for the class result with a timeout.
module nn_input_streamer #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_SAMPLES    = 784,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  input  logic [31:0]           nn_result,
  input  logic                  nn_result_valid,
  output logic                  busy,
  output logic [31:0]           result,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH:0] NUM  = (ADDR_WIDTH+1)'(NUM_SAMPLES);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(NUM_SAMPLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RESULT,
    DONE
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH:0]   idx;
  logic [ADDR_WIDTH:0]   nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [TW-1:0]         timer;
  logic                  fire;
  logic                  wr_ok;

  assign fire  = m_axis_valid && m_axis_ready;
  assign nxt   = idx + (ADDR_WIDTH+1)'(1);
  assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < NUM);

  // The read address is steered by the handshake so the next sample lands
  // in the output register on the same edge that retires the current one.
  assign rd_addr = (state == STREAM) ? nxt[ADDR_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      timer        <= '0;
      m_axis_data  <= '0;
      m_axis_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      timeout_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state        <= STREAM;
            busy         <= 1'b1;
            timeout_err  <= 1'b0;
            idx          <= '0;
            m_axis_data  <= mem[rd_addr];
            m_axis_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (fire) begin
            if (idx == LAST) begin
              m_axis_valid <= 1'b0;
              timer        <= '0;
              state        <= WAIT_RESULT;
            end else begin
              idx         <= nxt;
              m_axis_data <= mem[rd_addr];
            end
          end
        end
        WAIT_RESULT: begin
          if (nn_result_valid) begin
            result <= nn_result;
            done   <= 1'b1;
            state  <= DONE;
          end else if (timer == T_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
